spi_reg_bridge: RTL and testbench

- Parametrised SPI-slave (mode 0) to register-bus bridge; the next generation of the 4-bit-address / 8-bit-data SPI register access used by the peripheral test harness.
- Adds configurable address and data width, burst transfers with optional address auto-increment, an explicit read strobe, and framing-error reporting.
- Sits between the synchronised SPI pins and the peripheral register port (address / data_in / data_out / data_write).

---
 rtl/spi_bridge_pkg.sv | 22 ++
 rtl/spi_edge_detect.sv | 23 ++
 rtl/spi_reg_bridge.sv | 175 +++++++++++++++++
 tb/tb_spi_reg_bridge.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_bridge_pkg.sv
// Shared types and helpers for the SPI register bridge family.
package spi_bridge_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StWdata,
    StRdata
  } state_e;

  localparam logic RwWrite = 1'b1;

  // Counter must hold the longest field length (address or data word).
  function automatic int unsigned cnt_width(input int unsigned addr_w,
                                            input int unsigned data_w);
    int unsigned longest;
    longest = (addr_w > data_w) ? addr_w : data_w;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/spi_edge_detect.sv
// Registers a pre-synchronised SPI clock and emits one-cycle rise/fall pulses.
module spi_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic spi_clk_i,
  output logic rise_o,
  output logic fall_o
);

  logic spi_clk_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      spi_clk_q <= 1'b0;
    end else begin
      spi_clk_q <= spi_clk_i;
    end
  end

  assign rise_o = spi_clk_i & ~spi_clk_q;
  assign fall_o = ~spi_clk_i & spi_clk_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave to register-bus bridge with bursts, auto-increment and framing errors.
module spi_reg_bridge
  import spi_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned AUTO_INC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              spi_cs_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_data_i,
  output logic [DATA_W-1:0] reg_data_o,
  output logic              reg_wr,
  output logic              reg_rd,
  output logic              frame_err
);

  localparam int unsigned CntW = cnt_width(ADDR_W, DATA_W);
  localparam logic [ADDR_W-1:0] AddrStep = (AUTO_INC != 0) ? ADDR_W'(1) : '0;

  state_e            state_q, state_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_sh_q, addr_sh_d;
  logic [DATA_W-1:0] data_sh_q, data_sh_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d, rd_q, rd_d, ferr_q, ferr_d, miso_q, miso_d;
  logic              sclk_rise, sclk_fall, abort;

  spi_edge_detect u_edge (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .spi_clk_i(spi_clk),
    .rise_o   (sclk_rise),
    .fall_o   (sclk_fall)
  );

  assign abort = spi_cs_n | ~ena;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rw_d       = rw_q;
    addr_sh_d  = addr_sh_q;
    data_sh_d  = data_sh_q;
    reg_addr_d = reg_addr_q;
    wdata_d    = wdata_q;
    wr_d       = 1'b0;
    rd_d       = 1'b0;
    ferr_d     = 1'b0;
    miso_d     = miso_q;

    // Address advances the cycle after a write strobe; read data lands one cycle after reg_rd.
    if (wr_q) reg_addr_d = reg_addr_q + AddrStep;
    if (rd_q) data_sh_d = reg_data_i;

    unique case (state_q)
      StIdle: begin
        bit_cnt_d = '0;
        if (!abort) state_d = StCmd;
      end
      StCmd: begin
        if (abort) begin
          state_d = StIdle;
        end else if (sclk_rise) begin
          rw_d      = spi_mosi;
          bit_cnt_d = '0;
          state_d   = StAddr;
        end
      end
      StAddr: begin
        if (abort) begin
          state_d = StIdle;
          ferr_d  = 1'b1;
        end else if (sclk_rise) begin
          addr_sh_d = ADDR_W'({addr_sh_q, spi_mosi});
          if (bit_cnt_q == CntW'(ADDR_W - 1)) begin
            reg_addr_d = addr_sh_d;
            bit_cnt_d  = '0;
            if (rw_q == RwWrite) begin
              state_d = StWdata;
            end else begin
              state_d = StRdata;
              rd_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StWdata: begin
        if (abort) begin
          state_d = StIdle;
          ferr_d  = (bit_cnt_q != '0);
        end else if (sclk_rise) begin
          data_sh_d = DATA_W'({data_sh_q, spi_mosi});
          if (bit_cnt_q == CntW'(DATA_W - 1)) begin
            wdata_d   = data_sh_d;
            wr_d      = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StRdata: begin
        if (abort) begin
          state_d = StIdle;
          ferr_d  = (bit_cnt_q != '0);
        end else begin
          if (sclk_fall) begin
            miso_d    = data_sh_q[DATA_W-1];
            data_sh_d = data_sh_q << 1;
          end
          if (sclk_rise) begin
            if (bit_cnt_q == CntW'(DATA_W - 1)) begin
              // Prefetch the next burst word well before the following falling edge.
              bit_cnt_d  = '0;
              reg_addr_d = reg_addr_q + AddrStep;
              rd_d       = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d != StRdata) miso_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      rw_q       <= 1'b0;
      addr_sh_q  <= '0;
      data_sh_q  <= '0;
      reg_addr_q <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      ferr_q     <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rw_q       <= rw_d;
      addr_sh_q  <= addr_sh_d;
      data_sh_q  <= data_sh_d;
      reg_addr_q <= reg_addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      ferr_q     <= ferr_d;
      miso_q     <= miso_d;
    end
  end

  assign spi_miso   = miso_q;
  assign reg_addr   = reg_addr_q;
  assign reg_data_o = wdata_q;
  assign reg_wr     = wr_q;
  assign reg_rd     = rd_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: three configurations share one SPI host, checked against a bus model.
module tb_spi_reg_bridge;

  localparam int H = 4;  // host half-period in clk cycles (minimum allowed)

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, ena, sclk, mosi;
  logic [2:0]  cs_n, miso, wr, rd, fe;
  logic [3:0]  a0, a1;
  logic [5:0]  a2;
  logic [7:0]  wd0, wd1, rdi0, rdi1;
  logic [31:0] wd2, rdi2;
  logic [31:0] mem [256];
  logic [7:0]  addr_p [3];
  logic [31:0] wd_p [3];

  int aw [3]  = '{4, 4, 6};
  int dw [3]  = '{8, 8, 32};
  int inc [3] = '{1, 0, 1};

  assign rdi0 = mem[{4'b0, a0}][7:0];
  assign rdi1 = mem[{4'b0, a1}][7:0];
  assign rdi2 = mem[{2'b0, a2}];
  assign addr_p[0] = {4'b0, a0};
  assign addr_p[1] = {4'b0, a1};
  assign addr_p[2] = {2'b0, a2};
  assign wd_p[0] = {24'b0, wd0};
  assign wd_p[1] = {24'b0, wd1};
  assign wd_p[2] = wd2;

  spi_reg_bridge #(.ADDR_W(4), .DATA_W(8), .AUTO_INC(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .spi_cs_n(cs_n[0]), .spi_clk(sclk),
    .spi_mosi(mosi), .spi_miso(miso[0]), .reg_addr(a0), .reg_data_i(rdi0),
    .reg_data_o(wd0), .reg_wr(wr[0]), .reg_rd(rd[0]), .frame_err(fe[0])
  );
  spi_reg_bridge #(.ADDR_W(4), .DATA_W(8), .AUTO_INC(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .spi_cs_n(cs_n[1]), .spi_clk(sclk),
    .spi_mosi(mosi), .spi_miso(miso[1]), .reg_addr(a1), .reg_data_i(rdi1),
    .reg_data_o(wd1), .reg_wr(wr[1]), .reg_rd(rd[1]), .frame_err(fe[1])
  );
  spi_reg_bridge #(.ADDR_W(6), .DATA_W(32), .AUTO_INC(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .spi_cs_n(cs_n[2]), .spi_clk(sclk),
    .spi_mosi(mosi), .spi_miso(miso[2]), .reg_addr(a2), .reg_data_i(rdi2),
    .reg_data_o(wd2), .reg_wr(wr[2]), .reg_rd(rd[2]), .frame_err(fe[2])
  );

  // Bus monitor: logs strobes; checks happen against snapshots taken per frame.
  logic [7:0]  wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  logic [7:0]  rd_addr_q [$];
  int          fe_cnt = 0;
  int          overlap_cnt = 0;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (wr[i]) begin
        wr_addr_q.push_back(addr_p[i]);
        wr_data_q.push_back(wd_p[i]);
      end
      if (rd[i]) rd_addr_q.push_back(addr_p[i]);
      if (fe[i]) fe_cnt++;
      if (wr[i] && rd[i]) overlap_cnt++;
    end
  end

  int          passed = 0;
  int          total = 0;
  int          wr_s, rd_s, fe_s, ov_s;
  logic [31:0] tx_words [$];
  logic [31:0] rx_words [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic host_bit(input int d, input logic b, output logic s);
    @(negedge clk);
    mosi = b;
    repeat (H) @(negedge clk);
    s = miso[d];
    sclk = 1'b1;
    repeat (H) @(negedge clk);
    sclk = 1'b0;
  endtask

  // Full frame: command, address, nwords data words, then 'extra' bits of a partial word.
  task automatic run_frame(input int d, input logic rw, input int addr, input int nwords,
                           input int extra, input bit via_ena);
    logic s;
    logic [31:0] w;
    int nb;
    wr_s = wr_addr_q.size();
    rd_s = rd_addr_q.size();
    fe_s = fe_cnt;
    ov_s = overlap_cnt;
    rx_words.delete();
    while (tx_words.size() <= nwords) tx_words.push_back($urandom);
    @(negedge clk);
    cs_n[d] = 1'b0;
    repeat (H) @(negedge clk);
    host_bit(d, rw, s);
    for (int i = aw[d] - 1; i >= 0; i--) host_bit(d, addr[i], s);
    for (int k = 0; k <= nwords; k++) begin
      nb = (k < nwords) ? dw[d] : extra;
      w = '0;
      for (int i = 0; i < nb; i++) begin
        host_bit(d, tx_words[k][dw[d]-1-i], s);
        w = {w[30:0], s};
      end
      if (k < nwords) rx_words.push_back(w);
    end
    repeat (H) @(negedge clk);
    if (via_ena) begin
      ena = 1'b0;
      repeat (3) @(negedge clk);
    end
    cs_n[d] = 1'b1;
    ena = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic check_frame(input int d, input logic rw, input int addr, input int nwords,
                             input int exp_fe, input string tag);
    int a, mask;
    logic [31:0] dmask;
    mask  = (1 << aw[d]) - 1;
    dmask = (dw[d] == 32) ? 32'hFFFF_FFFF : ((32'd1 << dw[d]) - 1);
    a = addr & mask;
    if (rw) begin
      check({tag, "/wr_cnt"}, wr_addr_q.size() - wr_s, nwords);
      check({tag, "/rd_cnt"}, rd_addr_q.size() - rd_s, 0);
      for (int k = 0; k < nwords && wr_s + k < wr_addr_q.size(); k++) begin
        check({tag, "/wr_addr"}, wr_addr_q[wr_s+k], a);
        check({tag, "/wr_data"}, wr_data_q[wr_s+k], tx_words[k] & dmask);
        a = (a + inc[d]) & mask;
      end
    end else begin
      // Every completed word triggers a prefetch of the next address.
      check({tag, "/wr_cnt"}, wr_addr_q.size() - wr_s, 0);
      check({tag, "/rd_cnt"}, rd_addr_q.size() - rd_s, nwords + 1);
      for (int k = 0; k <= nwords && rd_s + k < rd_addr_q.size(); k++) begin
        check({tag, "/rd_addr"}, rd_addr_q[rd_s+k], a);
        if (k < nwords) check({tag, "/miso_word"}, rx_words[k], mem[a] & dmask);
        a = (a + inc[d]) & mask;
      end
    end
    check({tag, "/frame_err"}, fe_cnt - fe_s, exp_fe);
    check({tag, "/wr_rd_overlap"}, overlap_cnt - ov_s, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d, ad, nw, ex;
    logic rw, s;
    bit ve;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[5]    = 32'h0000_003C;
    mem[8'h2A] = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    ena   = 1'b1;
    cs_n  = 3'b111;
    sclk  = 1'b0;
    mosi  = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset/miso", miso[i], 0);
      check("reset/addr", addr_p[i], 0);
      check("reset/wdata", wd_p[i], 0);
      check("reset/strobes", {wr[i], rd[i], fe[i]}, 0);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    tx_words = '{32'hA5};
    run_frame(0, 1'b1, 3, 1, 0, 1'b0);
    check_frame(0, 1'b1, 3, 1, 0, "write_a5");

    tx_words.delete();
    run_frame(0, 1'b0, 5, 1, 0, 1'b0);
    check_frame(0, 1'b0, 5, 1, 0, "read_5");
    check("read_5/wdata_held", wd_p[0], 32'hA5);

    tx_words = '{32'h11, 32'h22, 32'h33};
    run_frame(0, 1'b1, 14, 3, 0, 1'b0);
    check_frame(0, 1'b1, 14, 3, 0, "burst_inc");
    run_frame(1, 1'b1, 14, 3, 0, 1'b0);
    check_frame(1, 1'b1, 14, 3, 0, "burst_noinc");

    tx_words = '{32'h00, 32'hC7};
    run_frame(0, 1'b1, 2, 0, 5, 1'b0);
    check_frame(0, 1'b1, 2, 0, 1, "abort_5bits");
    tx_words = '{32'h7E};
    run_frame(0, 1'b1, 9, 1, 0, 1'b0);
    check_frame(0, 1'b1, 9, 1, 0, "after_abort");

    tx_words = '{32'h00, 32'h3B};
    run_frame(0, 1'b1, 4, 0, 2, 1'b1);
    check_frame(0, 1'b1, 4, 0, 1, "ena_abort");

    tx_words.delete();
    run_frame(2, 1'b0, 8'h2A, 1, 0, 1'b0);
    check_frame(2, 1'b0, 8'h2A, 1, 0, "read_w32");

    // Reset in the middle of the address phase.
    @(negedge clk);
    cs_n[0] = 1'b0;
    repeat (H) @(negedge clk);
    host_bit(0, 1'b1, s);
    for (int i = 0; i < 3; i++) host_bit(0, 1'b0, s);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset/miso", miso[0], 0);
    check("midreset/addr", addr_p[0], 0);
    check("midreset/wdata", wd_p[0], 0);
    check("midreset/strobes", {wr[0], rd[0], fe[0]}, 0);
    cs_n[0] = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    tx_words = '{32'h5A};
    run_frame(0, 1'b1, 1, 1, 0, 1'b0);
    check_frame(0, 1'b1, 1, 1, 0, "post_reset_write");

    for (int n = 0; n < 12; n++) begin
      d  = $urandom_range(0, 2);
      rw = 1'($urandom_range(0, 1));
      ad = $urandom_range(0, (1 << aw[d]) - 1);
      nw = $urandom_range(0, 3);
      ex = ($urandom_range(0, 2) == 0) ? $urandom_range(1, dw[d] - 1) : 0;
      ve = 1'($urandom_range(0, 1));
      tx_words.delete();
      run_frame(d, rw, ad, nw, ex, ve);
      check_frame(d, rw, ad, nw, (ex > 0) ? 1 : 0, "random");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
